pipe_stage_reg: RTL and testbench

Parametrised pipeline-stage register for the pipelined CPU datapath. It replaces the fixed-width bare D_FF register banks between stages.
- Adds a valid/ready handshake for stall propagation and a synchronous flush for bubble insertion.
- Uses a WIDTH-bit data payload.
- Instantiated once per inter-stage boundary (IF/ID, ID/EX, EX/MEM, MEM/WB) with the payload width of that boundary.

---
 rtl/pipe_stage_reg.sv | 109 ++++++++++
 tb/tb_pipe_stage_reg.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// Pipeline-stage register with valid/ready handshake and synchronous flush.
// Define PIPE_STAGE_REG_SKID_EN to build a 2-entry skid buffer with a registered in_ready.
module pipe_stage_reg #(
    parameter int unsigned      WIDTH        = 64,
    parameter logic [WIDTH-1:0] BUBBLE_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    input  logic             flush
);

    logic             up_xfer;
    logic             dn_xfer;
    logic [WIDTH-1:0] data_p0;

    assign out_data = data_p0;
    assign up_xfer  = in_valid & in_ready;
    assign dn_xfer  = out_valid & out_ready;

`ifdef PIPE_STAGE_REG_SKID_EN

    localparam logic [1:0] EMPTY = 2'd0;
    localparam logic [1:0] ONE   = 2'd1;
    localparam logic [1:0] FULL  = 2'd2;

    logic [1:0]       state_p0;
    logic [1:0]       state_nxt;
    logic             rdy_p0;
    logic [WIDTH-1:0] skid_p1;

    assign out_valid = (state_p0 != EMPTY);
    // Flush drains both entries, so it may accept (and drop) a beat even from FULL.
    assign in_ready  = rdy_p0 | flush;

    always_comb begin
        state_nxt = state_p0;
        if (flush) begin
            state_nxt = EMPTY;
        end else begin
            case (state_p0)
                EMPTY: if (up_xfer) state_nxt = ONE;
                ONE: begin
                    if (up_xfer && !dn_xfer)
                        state_nxt = FULL;
                    else if (!up_xfer && dn_xfer)
                        state_nxt = EMPTY;
                end
                FULL:    if (dn_xfer) state_nxt = ONE;
                default: state_nxt = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_p0 <= EMPTY;
            rdy_p0   <= 1'b1;
            data_p0  <= BUBBLE_VALUE;
        end else begin
            state_p0 <= state_nxt;
            rdy_p0   <= (state_nxt != FULL);
            if (flush) begin
                data_p0 <= BUBBLE_VALUE;
            end else if (state_p0 == FULL) begin
                if (dn_xfer)
                    data_p0 <= skid_p1;
            end else if (up_xfer && (state_p0 == EMPTY || dn_xfer)) begin
                data_p0 <= in_data;
            end
        end
    end

    // Skid entry is only meaningful while state is FULL, so it carries no reset.
    always_ff @(posedge clk) begin
        if (!flush && state_p0 == ONE && up_xfer && !dn_xfer)
            skid_p1 <= in_data;
    end

`else

    logic vld_p0;

    assign out_valid = vld_p0;
    assign in_ready  = out_ready | ~vld_p0 | flush;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_p0  <= 1'b0;
            data_p0 <= BUBBLE_VALUE;
        end else if (flush) begin
            vld_p0  <= 1'b0;
            data_p0 <= BUBBLE_VALUE;
        end else if (up_xfer) begin
            vld_p0  <= 1'b1;
            data_p0 <= in_data;
        end else if (dn_xfer) begin
            vld_p0  <= 1'b0;
        end
    end

`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: vector table plus stall, reset, flush and width sweeps.
module tb_pipe_stage_reg;

    logic        clk;
    logic        reset;
    logic [63:0] in_data, out_data;
    logic        in_valid, in_ready, out_valid, out_ready, flush;

    logic [4:0]  s5_id, s5_od;
    logic        s5_iv, s5_ir, s5_ov, s5_or, s5_fl;
    logic [31:0] s32_id, s32_od;
    logic        s32_iv, s32_ir, s32_ov, s32_or, s32_fl;

    int n_cmp = 0;
    int n_err = 0;

    pipe_stage_reg #(.WIDTH(64), .BUBBLE_VALUE(64'h0)) dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .flush(flush));

    pipe_stage_reg #(.WIDTH(5), .BUBBLE_VALUE(5'h1F)) dut5 (
        .clk(clk), .reset(reset), .in_data(s5_id), .in_valid(s5_iv),
        .in_ready(s5_ir), .out_data(s5_od), .out_valid(s5_ov),
        .out_ready(s5_or), .flush(s5_fl));

    pipe_stage_reg #(.WIDTH(32), .BUBBLE_VALUE(32'hCAFE_F00D)) dut32 (
        .clk(clk), .reset(reset), .in_data(s32_id), .in_valid(s32_iv),
        .in_ready(s32_ir), .out_data(s32_od), .out_valid(s32_ov),
        .out_ready(s32_or), .flush(s32_fl));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        iv;
        logic [63:0] d;
        logic        ordy;
        logic        fl;
        logic        exp_rdy;
        logic        exp_ov;
        logic [63:0] exp_od;
    } vec_t;

    vec_t tbl [13];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic iv, input logic [63:0] d, input logic ordy, input logic fl);
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
    endtask

    task automatic edge_step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        tbl[0]  = '{1'b1, 64'h11, 1'b1, 1'b0, 1'b1, 1'b1, 64'h11};
        tbl[1]  = '{1'b1, 64'h22, 1'b1, 1'b0, 1'b1, 1'b1, 64'h22};
        tbl[2]  = '{1'b1, 64'h33, 1'b1, 1'b0, 1'b1, 1'b1, 64'h33};
        tbl[3]  = '{1'b0, 64'h44, 1'b1, 1'b0, 1'b1, 1'b0, 64'h33};
        tbl[4]  = '{1'b0, 64'h44, 1'b0, 1'b0, 1'b1, 1'b0, 64'h33};
        tbl[5]  = '{1'b1, 64'h55, 1'b0, 1'b0, 1'b1, 1'b1, 64'h55};
        tbl[6]  = '{1'b1, 64'h66, 1'b0, 1'b1, 1'b1, 1'b0, 64'h0};
        tbl[7]  = '{1'b0, 64'h66, 1'b1, 1'b0, 1'b1, 1'b0, 64'h0};
        tbl[8]  = '{1'b1, 64'h77, 1'b0, 1'b0, 1'b1, 1'b1, 64'h77};
        tbl[9]  = '{1'b0, 64'h0,  1'b1, 1'b0, 1'b1, 1'b0, 64'h77};
        tbl[10] = '{1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF};
        tbl[11] = '{1'b1, 64'h8000_0000_0000_0001, 1'b1, 1'b0, 1'b1, 1'b1, 64'h8000_0000_0000_0001};
        tbl[12] = '{1'b0, 64'h0,  1'b1, 1'b1, 1'b1, 1'b0, 64'h0};

        reset = 1'b0;
        drive(1'b0, 64'h0, 1'b0, 1'b0);
        s5_id = '0;  s5_iv = 1'b0;  s5_or = 1'b1;  s5_fl = 1'b0;
        s32_id = '0; s32_iv = 1'b0; s32_or = 1'b1; s32_fl = 1'b0;

        // Reset state, observed while reset is still asserted
        #2 reset = 1'b1;
        #1;
        chk("rst_ov", {63'd0, out_valid}, 64'd0);
        chk("rst_od", out_data, 64'h0);
        chk("rst5_od", {59'd0, s5_od}, 64'h1F);
        chk("rst32_od", {32'd0, s32_od}, 64'hCAFE_F00D);
        chk("rst32_ov", {63'd0, s32_ov}, 64'd0);
        edge_step();
        reset = 1'b0;
        #1;
        chk("rst_rdy", {63'd0, in_ready}, 64'd1);

        for (int i = 0; i < 13; i++) begin
            drive(tbl[i].iv, tbl[i].d, tbl[i].ordy, tbl[i].fl);
            #1;
            chk($sformatf("tbl%0d_rdy", i), {63'd0, in_ready}, {63'd0, tbl[i].exp_rdy});
            edge_step();
            chk($sformatf("tbl%0d_ov", i), {63'd0, out_valid}, {63'd0, tbl[i].exp_ov});
            chk($sformatf("tbl%0d_od", i), out_data, tbl[i].exp_od);
        end

        // Stall: 0xAA held while downstream is blocked for 3 cycles
        drive(1'b1, 64'hAA, 1'b0, 1'b0);
        edge_step();
        chk("stall_load_od", out_data, 64'hAA);
`ifdef PIPE_STAGE_REG_SKID_EN
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, (k == 0) ? 64'hBB : 64'hCC, 1'b0, 1'b0);
            #1;
            chk($sformatf("stall%0d_rdy", k), {63'd0, in_ready}, (k == 0) ? 64'd1 : 64'd0);
            edge_step();
            chk($sformatf("stall%0d_od", k), out_data, 64'hAA);
            chk($sformatf("stall%0d_ov", k), {63'd0, out_valid}, 64'd1);
        end
        drive(1'b0, 64'h0, 1'b1, 1'b0);
        #1;
        chk("rel_rdy", {63'd0, in_ready}, 64'd0);
        edge_step();
        chk("rel_od", out_data, 64'hBB);
        chk("rel_ov", {63'd0, out_valid}, 64'd1);
        #1;
        chk("rel2_rdy", {63'd0, in_ready}, 64'd1);
`else
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 64'hBB, 1'b0, 1'b0);
            #1;
            chk($sformatf("stall%0d_rdy", k), {63'd0, in_ready}, 64'd0);
            edge_step();
            chk($sformatf("stall%0d_od", k), out_data, 64'hAA);
            chk($sformatf("stall%0d_ov", k), {63'd0, out_valid}, 64'd1);
        end
        drive(1'b1, 64'hBB, 1'b1, 1'b0);
        #1;
        chk("rel_rdy", {63'd0, in_ready}, 64'd1);
        edge_step();
        chk("rel_od", out_data, 64'hBB);
        chk("rel_ov", {63'd0, out_valid}, 64'd1);
        drive(1'b0, 64'h0, 1'b1, 1'b0);
`endif
        edge_step();
        chk("drain_ov", {63'd0, out_valid}, 64'd0);
        chk("drain_od", out_data, 64'hBB);

        // Reset asserted mid-cycle with a live beat held
        drive(1'b1, 64'h99, 1'b0, 1'b0);
        edge_step();
        chk("pre_rst_od", out_data, 64'h99);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_ov", {63'd0, out_valid}, 64'd0);
        chk("mid_rst_od", out_data, 64'h0);
        edge_step();
        reset = 1'b0;
        drive(1'b0, 64'h0, 1'b0, 1'b0);
        #1;
        chk("post_rst_rdy", {63'd0, in_ready}, 64'd1);
        edge_step();
        chk("post_rst_ov", {63'd0, out_valid}, 64'd0);

`ifdef PIPE_STAGE_REG_SKID_EN
        // Flush while both entries are occupied
        drive(1'b1, 64'h01, 1'b0, 1'b0);
        edge_step();
        drive(1'b1, 64'h02, 1'b0, 1'b0);
        edge_step();
        chk("full_od", out_data, 64'h01);
        chk("full_rdy", {63'd0, in_ready}, 64'd0);
        drive(1'b0, 64'h0, 1'b0, 1'b1);
        #1;
        chk("full_fl_rdy", {63'd0, in_ready}, 64'd1);
        edge_step();
        chk("full_fl_ov", {63'd0, out_valid}, 64'd0);
        chk("full_fl_od", out_data, 64'h0);
        drive(1'b0, 64'h0, 1'b1, 1'b0);
        #1;
        chk("full_fl_rdy2", {63'd0, in_ready}, 64'd1);
        edge_step();
        chk("full_fl_ov2", {63'd0, out_valid}, 64'd0);
        chk("full_fl_od2", out_data, 64'h0);
`endif

        // Width sweep: bit-exact pass-through and bubble loading
        s5_iv = 1'b1;  s5_id = 5'h0A;
        s32_iv = 1'b1; s32_id = 32'h1234_5678;
        edge_step();
        chk("w5_od_a", {59'd0, s5_od}, 64'h0A);
        chk("w5_ov_a", {63'd0, s5_ov}, 64'd1);
        chk("w32_od_a", {32'd0, s32_od}, 64'h1234_5678);
        s5_id = 5'h15; s32_id = 32'hA5A5_5A5A;
        edge_step();
        chk("w5_od_b", {59'd0, s5_od}, 64'h15);
        chk("w32_od_b", {32'd0, s32_od}, 64'hA5A5_5A5A);
        s5_fl = 1'b1;  s5_id = 5'h03;
        s32_fl = 1'b1; s32_id = 32'h0000_0003;
        edge_step();
        chk("w5_fl_od", {59'd0, s5_od}, 64'h1F);
        chk("w5_fl_ov", {63'd0, s5_ov}, 64'd0);
        chk("w32_fl_od", {32'd0, s32_od}, 64'hCAFE_F00D);
        chk("w32_fl_ov", {63'd0, s32_ov}, 64'd0);
        s5_fl = 1'b0;  s5_iv = 1'b0;
        s32_fl = 1'b0; s32_iv = 1'b0;
        edge_step();
        chk("w5_idle_ov", {63'd0, s5_ov}, 64'd0);
        chk("w32_idle_od", {32'd0, s32_od}, 64'hCAFE_F00D);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
